bist_march_ctrl: RTL and testbench

Controller that sequences an accumulator-based pattern generator to run a two-pass write/read self-test over a small RAM.
- Write pass: fills every address with the accumulator sequence.
- Read pass: regenerates the same sequence and compares it against the RAM read data.
- Sits between the BIST top level (start/done/fail handshake) and the RAM under test (address, write-enable, write/read data).

---
 rtl/bist_march_ctrl_pkg.sv | 17 +
 rtl/bist_march_ctrl_pattern_acc.sv | 35 +++
 rtl/bist_march_ctrl.sv | 118 +++++++++++
 tb/tb_bist_march_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/bist_march_ctrl_pkg.sv
// Shared definitions for the march BIST controller: FSM state encoding and
// default geometry / pattern seed.
package bist_march_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int         DEF_ADDR_W = 4;
  localparam int         DEF_DATA_W = 3;
  localparam logic [2:0] DEF_SEED   = 3'd3;

endpackage

// File: rtl/bist_march_ctrl_pattern_acc.sv
// Pattern generator: DATA_W-bit accumulator adding SEED each step, with the
// carry-out registered and fed back into the following step.
module bist_pattern_acc
  import bist_march_ctrl_pkg::*;
#(
  parameter int                DATA_W = DEF_DATA_W,
  parameter logic [DATA_W-1:0] SEED   = DEF_SEED
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              step,
  output logic [DATA_W-1:0] acc
);

  logic          carry_q;
  logic [DATA_W:0] sum;

  assign sum = {1'b0, acc} + {1'b0, SEED} + {{DATA_W{1'b0}}, carry_q};

  // clear wins over step so the last write cycle rewinds for the read pass
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      carry_q <= 1'b0;
    end else if (clear) begin
      acc     <= '0;
      carry_q <= 1'b0;
    end else if (step) begin
      acc     <= sum[DATA_W-1:0];
      carry_q <= sum[DATA_W];
    end
  end

endmodule

// File: rtl/bist_march_ctrl.sv
// Two-pass (write, then read/compare) RAM self-test controller.
// Optional BIST_ERR_COUNT_EN adds a saturating mismatch counter output err_count.
module bist_march_ctrl
  import bist_march_ctrl_pkg::*;
#(
  parameter int                ADDR_W = DEF_ADDR_W,
  parameter int                DATA_W = DEF_DATA_W,
  parameter logic [DATA_W-1:0] SEED   = DEF_SEED
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef BIST_ERR_COUNT_EN
  ,
  output logic [ADDR_W:0]   err_count
`endif
);

  localparam logic [ADDR_W-1:0] LAST    = '1;
  localparam logic [ADDR_W-1:0] CNT_ONE = ADDR_W'(1);

  state_e            state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] exp_q;
  logic [ADDR_W-1:0] addr_q;
  logic              cmp_vld;
  logic              acc_clear;
  logic              acc_step;
  logic              mismatch;

  assign acc_clear = ((state == ST_IDLE) && start) || ((state == ST_WRITE) && (cnt == LAST));
  assign acc_step  = (state == ST_WRITE) || (state == ST_READ);
  assign ram_addr  = cnt;
  assign ram_wdata = ram_we ? acc : '0;
  assign mismatch  = cmp_vld && (ram_rdata != exp_q);

  bist_pattern_acc #(.DATA_W(DATA_W), .SEED(SEED)) u_acc (
    .clk   (clk),
    .reset (reset),
    .clear (acc_clear),
    .step  (acc_step),
    .acc   (acc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= '0;
      ram_we    <= 1'b0;
      cnt       <= '0;
      exp_q     <= '0;
      addr_q    <= '0;
      cmp_vld   <= 1'b0;
`ifdef BIST_ERR_COUNT_EN
      err_count <= '0;
`endif
    end else begin
      done    <= 1'b0;
      // read data lags the address by one cycle; align expectation with it
      cmp_vld <= (state == ST_READ);
      exp_q   <= acc;
      addr_q  <= cnt;
      if (mismatch) begin
        if (!fail) begin
          fail      <= 1'b1;
          fail_addr <= addr_q;
        end
`ifdef BIST_ERR_COUNT_EN
        if (err_count != '1) err_count <= err_count + (ADDR_W+1)'(1);
`endif
      end
      case (state)
        ST_IDLE: if (start) begin
          state     <= ST_WRITE;
          busy      <= 1'b1;
          ram_we    <= 1'b1;
          cnt       <= '0;
          fail      <= 1'b0;
          fail_addr <= '0;
`ifdef BIST_ERR_COUNT_EN
          err_count <= '0;
`endif
        end
        ST_WRITE: begin
          cnt <= cnt + CNT_ONE;  // wraps to 0 after the last address
          if (cnt == LAST) begin
            state  <= ST_READ;
            ram_we <= 1'b0;
          end
        end
        ST_READ: begin
          if (cnt == LAST) state <= ST_DRAIN;
          else             cnt   <= cnt + CNT_ONE;
        end
        ST_DRAIN: begin
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bist_march_ctrl.sv
// Bench for bist_march_ctrl: RAM model with fault injection plus a
// cycle-indexed reference model checked on every falling edge.
module tb_bist_march_ctrl;
  localparam int N = 16;
  localparam int TEST_CYC = 2*N + 2;

  logic       clk, reset, start;
  logic       busy, done, fail, ram_we;
  logic [3:0] fail_addr, ram_addr;
  logic [2:0] ram_wdata, ram_rdata;
`ifdef BIST_ERR_COUNT_EN
  logic [4:0] err_count;
`endif

  bist_march_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .fail(fail), .fail_addr(fail_addr), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
`ifdef BIST_ERR_COUNT_EN
    , .err_count(err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // RAM under test with per-address stuck read values
  logic [2:0] mem [N];
  bit         flt_en [N];
  int         flt_val [N];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= flt_en[ram_addr] ? 3'(flt_val[ram_addr]) : mem[ram_addr];
  end

  // reference: pattern list from plain modular arithmetic, outputs from cycle index
  int pat [N];
  int m_t, m_fail, m_faddr, m_err;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_t <= 0; m_fail <= 0; m_faddr <= 0; m_err <= 0;
    end else if (m_t == 0) begin
      if (start) begin m_t <= 1; m_fail <= 0; m_faddr <= 0; m_err <= 0; end
    end else begin
      if (m_t >= N+2 && m_t <= 2*N+1 && flt_en[m_t-N-2] && flt_val[m_t-N-2] != pat[m_t-N-2]) begin
        if (m_fail == 0) begin m_fail <= 1; m_faddr <= m_t-N-2; end
        if (m_err != 31) m_err <= m_err + 1;
      end
      m_t <= (m_t == TEST_CYC) ? 0 : m_t + 1;
    end
  end

  always @(negedge clk) begin
    int we_e, busy_e, addr_e;
    we_e   = (m_t >= 1 && m_t <= N) ? 1 : 0;
    busy_e = (m_t >= 1 && m_t <= 2*N+1) ? 1 : 0;
    addr_e = (m_t <= N) ? m_t-1 : (m_t <= 2*N) ? m_t-N-1 : N-1;
    chk("busy", busy, busy_e);
    chk("done", done, (m_t == TEST_CYC) ? 1 : 0);
    chk("ram_we", ram_we, we_e);
    chk("ram_wdata", ram_wdata, we_e ? pat[m_t-1] : 0);
    if (busy_e) chk("ram_addr", ram_addr, addr_e);
    chk("fail", fail, m_fail);
    if (m_fail != 0) chk("fail_addr", fail_addr, m_faddr);
`ifdef BIST_ERR_COUNT_EN
    chk("err_count", err_count, m_err);
`endif
  end

  task automatic set_faults(input int a0, input int v0, input int a1, input int v1);
    for (int i = 0; i < N; i++) begin flt_en[i] = 0; flt_val[i] = 0; end
    if (a0 >= 0) begin flt_en[a0] = 1; flt_val[a0] = v0; end
    if (a1 >= 0) begin flt_en[a1] = 1; flt_val[a1] = v1; end
  endtask

  // start a test; optionally re-pulse start at cycle pulse_at (34 = during DONE)
  task automatic run_test(input int pulse_at, output int lat);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; lat = 1;
    while (!done && lat < 100) begin
      start = (lat == pulse_at) ? 1'b1 : 1'b0;
      @(negedge clk); lat++;
    end
    start = (pulse_at == TEST_CYC) ? 1'b1 : 1'b0;
    @(negedge clk); start = 1'b0;
  endtask

  initial begin
    int lat;
    int lit [8] = '{0, 3, 6, 1, 5, 0, 4, 7};
    int a, c, s;
    reset = 1'b1; start = 1'b0;
    set_faults(-1, 0, -1, 0);
    for (int i = 0; i < N; i++) mem[i] = '0;
    a = 0; c = 0;
    for (int i = 0; i < N; i++) begin
      pat[i] = a; s = a + 3 + c; a = s % 8; c = s / 8;
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    repeat (10) @(negedge clk);
    chk("idle_busy", busy, 0); chk("idle_done", done, 0); chk("idle_fail", fail, 0);
    chk("idle_we", ram_we, 0); chk("idle_addr", ram_addr, 0);
    for (int i = 0; i < 8; i++) chk("pattern_seq", pat[i], lit[i]);
    chk("pattern_15", pat[15], 2);

    run_test(0, lat);
    chk("clean_latency", lat, 34); chk("clean_fail", fail, 0);

    set_faults(5, 7, -1, 0);
    run_test(0, lat);
    chk("f5_latency", lat, 34); chk("f5_fail", fail, 1); chk("f5_addr", fail_addr, 5);
`ifdef BIST_ERR_COUNT_EN
    chk("f5_errcnt", err_count, 1);
`endif

    set_faults(2, 7, 9, 0);
    run_test(0, lat);
    chk("f2_9_fail", fail, 1); chk("f2_9_addr", fail_addr, 2);
`ifdef BIST_ERR_COUNT_EN
    chk("f2_9_errcnt", err_count, 2);
`endif

    set_faults(15, 7, -1, 0);
    run_test(0, lat);
    chk("f15_fail", fail, 1); chk("f15_addr", fail_addr, 15);

    // restart after a failing run, with ignored start pulses in WRITE and DONE
    set_faults(-1, 0, -1, 0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("accept_clears_fail", fail, 0);
    lat = 1;
    while (!done && lat < 100) begin
      start = (lat == 5) ? 1'b1 : 1'b0;
      @(negedge clk); lat++;
    end
    chk("ignored_latency", lat, 34); chk("ignored_fail", fail, 0);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("done_start_ignored", busy, 0);
    @(negedge clk);
    chk("still_idle", busy, 0);

    // reset mid-read at address 6
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    lat = 0;
    while (m_t != N+7 && lat < 60) begin @(negedge clk); lat++; end
    chk("read6_addr", ram_addr, 6);
    chk("read6_we", ram_we, 0);
    #2 reset = 1'b1;
    #1;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_fail", fail, 0);
    chk("rst_we", ram_we, 0); chk("rst_addr", ram_addr, 0);
    chk("rst_wdata", ram_wdata, 0); chk("rst_faddr", fail_addr, 0);
    @(negedge clk); reset = 1'b0;
    run_test(0, lat);
    chk("post_rst_latency", lat, 34); chk("post_rst_fail", fail, 0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
